// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, 34-cycle
// fixed latency from start to done. Quotient goes to LO, remainder to HI.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] dividend_orig;
  logic [4:0]       cnt;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // 0x80000000 negates to itself, which is the correct magnitude read unsigned.
  always_comb begin
    dividend_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted      = {rem, quo[WIDTH-1]};
    trial        = shifted - {1'b0, dmag};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem           <= '0;
      quo           <= '0;
      dmag          <= '0;
      dividend_orig <= '0;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      zero_div      <= 1'b0;
      done          <= 1'b0;
      q             <= '0;
      r             <= '0;
      div_zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem           <= '0;
            quo           <= dividend_mag;
            dmag          <= divisor_mag;
            dividend_orig <= dividend;
            cnt           <= '0;
            neg_q         <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r         <= sign & dividend[WIDTH-1];
            zero_div      <= (divisor == '0);
          end
        end
        RUN: begin
          // Partial remainder stays below the divisor, so the top bit of the
          // trial difference alone decides keep versus restore.
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          done <= 1'b1;
          if (zero_div) begin
            q        <= '1;
            r        <= dividend_orig;
            div_zero <= 1'b1;
          end else begin
            q        <= neg_q ? -quo : quo;
            r        <= neg_r ? -rem : rem;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, ignored starts, back-to-back and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle; returns in cycle 1 of the operation.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the cycle number (1-based from the start edge) in which done is seen.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        n = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    reset = 1'b0;
    vectors++;
    if ({busy, done, div_zero} !== 3'b000 || q !== 32'd0 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, want all zero", busy, done, div_zero, q, r);
    end
  endtask

  task automatic test_unsigned_timing();
    int bad_cycle;
    issue(1'b0, 32'd100, 32'd7);
    bad_cycle = 0;
    for (int c = 1; c <= 33; c++) begin
      if (!(busy === 1'b1 && done === 1'b0) && bad_cycle == 0) bad_cycle = c;
      step();
    end
    vectors++;
    if (bad_cycle != 0) begin
      miscompares++;
      $display("FAIL busy_window: busy/done wrong at cycle %0d, want busy=1 done=0 in 1..33", bad_cycle);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_cycle34: done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    vectors++;
    if (q !== 32'd14 || r !== 32'd2 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL u100_7: q=%0d r=%0d dz=%b, want q=14 r=2 dz=0", q, r, div_zero);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: done=%b in cycle 35, want 0", done);
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  task automatic test_results();
    vec_t v[9];
    int n;
    v[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    v[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    v[2] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
    v[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    v[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    v[5] = '{1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
    v[6] = '{1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
    v[7] = '{1'b1, 32'h80000005, 32'd0,        32'hFFFFFFFF, 32'h80000005, 1'b1};
    v[8] = '{1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(v[i].s, v[i].a, v[i].b);
      wait_done(n);
      vectors++;
      if (n != 34) begin
        miscompares++;
        $display("FAIL latency[%0d]: done at cycle %0d, want 34", i, n);
      end
      vectors++;
      if (q !== v[i].eq || r !== v[i].er || div_zero !== v[i].edz) begin
        miscompares++;
        $display("FAIL result[%0d]: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                 i, q, r, div_zero, v[i].eq, v[i].er, v[i].edz);
      end
      step();
    end
  endtask

  task automatic test_ignored_start();
    int n;
    int seen;
    issue(1'b0, 32'd1000, 32'd10);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        n = c;
        break;
      end
      if (c == 5 || c == 20) begin
        start = 1'b1; sign = 1'b1; dividend = 32'hFFFFFF00 + c; divisor = 32'd3;
      end else begin
        start = 1'b0; dividend = 32'd55; divisor = 32'd0;
      end
      step();
    end
    start = 1'b0;
    vectors++;
    if (n != 34 || q !== 32'd100 || r !== 32'd0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_start: cycle=%0d q=%0d r=%0d dz=%b, want cycle=34 q=100 r=0 dz=0", n, q, r, div_zero);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL ignored_start_quiet: %0d cycles with busy/done after result, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(1'b0, 32'd20, 32'd6);
    wait_done(n);
    vectors++;
    if (n != 34 || q !== 32'd3 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_first: cycle=%0d q=%0d r=%0d, want cycle=34 q=3 r=2", n, q, r);
    end
    issue(1'b0, 32'd50, 32'd7);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_done(n);
    vectors++;
    if (n != 34 || q !== 32'd7 || r !== 32'd1) begin
      miscompares++;
      $display("FAIL b2b_second: cycle=%0d q=%0d r=%0d, want cycle=34 q=7 r=1", n, q, r);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    int n;
    issue(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c < 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b q=%h r=%h dz=%b, want 0", busy, q, r, div_zero);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen++;
      step();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_nodone: %0d done pulses after abort, want 0", seen);
    end
    reset = 1'b1;
    issue(1'b0, 32'd8, 32'd2);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_same: busy=%b, want 0", busy);
    end
    issue(1'b0, 32'd9, 32'd3);
    wait_done(n);
    vectors++;
    if (n != 34 || q !== 32'd3 || r !== 32'd0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover: cycle=%0d q=%0d r=%0d dz=%b, want cycle=34 q=3 r=0 dz=0", n, q, r, div_zero);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_timing();
    test_results();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
